prefetch_sched: RTL and testbench

- Round-robin scheduler that shares one 3D spatial prefetch engine among N_REQ requesters.
- Accepts one base address at a time and starts the engine with it.
- Buffers the engine's neighbour-address candidates, tagged with the owning requester ID, in an internal FIFO and drains them to the NAND read-queue side over a valid/ready port.
- A watchdog recovers from an engine that never signals completion.

---
 rtl/prefetch_sched.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_prefetch_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_sched.sv
// -----------------------------------------------------------------------------
// prefetch_sched
//
// Round-robin scheduler that shares one 3D spatial prefetch engine among N_REQ
// requesters. It accepts one base address at a time and starts the engine with
// it. The engine's neighbour-address candidates are tagged with the owning
// requester ID and buffered in a FIFO that drains over a valid/ready port
// towards the NAND read queue. A watchdog abandons a run whose engine never
// reports done.
//
// Optional build macro:
//   PREFETCH_SCHED_DEDUP_EN - keep a 4-entry history of recently issued base
//                             addresses and drop candidates that match one.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   req_valid_i         per-requester request valid
//   req_addr_i          flattened base addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready_o         one-hot accept for the round-robin winner (IDLE only)
//   eng_start_o         one-cycle engine start pulse
//   eng_addr_o          base address of the current/last run
//   eng_cand_valid_i    engine candidate valid
//   eng_cand_addr_i     engine candidate address
//   eng_done_i          engine run finished (may coincide with last candidate)
//   out_valid_o         FIFO head available
//   out_ready_i         downstream accept
//   out_addr_o          FIFO head candidate address
//   out_id_o            FIFO head owning requester
//   busy_o              high whenever the scheduler is not idle
//   timeout_o           one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module prefetch_sched #(
    parameter int ADDR_WIDTH     = 32,
    parameter int N_REQ          = 4,
    parameter int ID_W           = $clog2(N_REQ),
    parameter int MAX_CAND       = 6,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        eng_start_o,
    output logic [ADDR_WIDTH-1:0]       eng_addr_o,
    input  logic                        eng_cand_valid_i,
    input  logic [ADDR_WIDTH-1:0]       eng_cand_addr_i,
    input  logic                        eng_done_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [ADDR_WIDTH-1:0]       out_addr_o,
    output logic [ID_W-1:0]             out_id_o,
    output logic                        busy_o,
    output logic                        timeout_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [ADDR_WIDTH-1:0] addr;
    } cand_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [ADDR_WIDTH-1:0] base_addr_q;
    logic [ID_W-1:0]       base_id_q;
    logic [WD_W-1:0]       wdog_q;

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    cand_t                 fifo_mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] req_addr [N_REQ];
    logic [N_REQ-1:0]      req_rot;
    logic                  any_req;
    logic [ID_W-1:0]       win_id;
    logic [ID_W:0]         win_sum;
    logic [N_REQ-1:0]      win_onehot;
    logic                  has_space;
    logic                  accept;

    logic                  fifo_full;
    logic                  dup_hit;
    logic                  push;
    logic                  pop;
    cand_t                 head;

    // -------------------------------------------------------------------------
    // Round-robin arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            req_addr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Rotate the request vector so bit 0 is the requester at the RR pointer;
    // the first set bit of the rotated vector is then the winner's offset.
    assign req_rot = N_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);

    always_comb begin
        any_req = 1'b0;
        win_sum = '0;
        win_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_req && req_rot[i]) begin
                any_req = 1'b1;
                win_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            end
        end
        // rr_ptr < N_REQ and offset < N_REQ, so one subtraction wraps it.
        if (win_sum >= (ID_W+1)'(N_REQ)) begin
            win_sum = win_sum - (ID_W+1)'(N_REQ);
        end
        win_id = win_sum[ID_W-1:0];
    end

    assign win_onehot = N_REQ'(1) << win_id;

    // A run can deliver up to MAX_CAND candidates, so only start one when the
    // FIFO can absorb all of them even if nothing drains meanwhile.
    assign has_space = (CNT_W'(FIFO_DEPTH) - count_q) >= CNT_W'(MAX_CAND);
    assign accept    = (state_q == IDLE) && any_req && has_space;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        eng_start_o = 1'b0;
        timeout_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready_o = win_onehot;
                    state_d     = START;
                end
            end
            START: begin
                eng_start_o = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (eng_done_i) begin
                    state_d = IDLE;
                end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_o = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign eng_addr_o = base_addr_q;

    // Latched request, round-robin pointer and watchdog.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            base_addr_q <= '0;
            base_id_q   <= '0;
            wdog_q      <= '0;
        end else begin
            if (accept) begin
                base_addr_q <= req_addr[win_id];
                base_id_q   <= win_id;
                rr_ptr_q    <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
            end
            if (state_q == START) begin
                wdog_q <= '0;
            end else if (state_q == WAIT) begin
                wdog_q <= wdog_q + WD_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Duplicate filter
    // -------------------------------------------------------------------------
`ifdef PREFETCH_SCHED_DEDUP_EN
    localparam int HIST_N = 4;

    logic [ADDR_WIDTH-1:0] hist_addr [HIST_N];
    logic [HIST_N-1:0]     hist_valid_q;
    logic [1:0]            hist_ptr_q;

    // Only the valid bits and the replacement pointer need a reset; the
    // address slots are never consulted while their valid bit is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_valid_q <= '0;
            hist_ptr_q   <= '0;
        end else if (state_q == START) begin
            hist_valid_q[hist_ptr_q] <= 1'b1;
            hist_ptr_q               <= hist_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == START) begin
            hist_addr[hist_ptr_q] <= base_addr_q;
        end
    end

    // The current run's base is already in the history during WAIT, so an
    // engine echoing its own base address is filtered as well.
    always_comb begin
        dup_hit = 1'b0;
        for (int h = 0; h < HIST_N; h++) begin
            if (hist_valid_q[h] && (hist_addr[h] == eng_cand_addr_i)) begin
                dup_hit = 1'b1;
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Candidate FIFO
    // -------------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    // Stray candidates outside WAIT and excess candidates on a full FIFO are
    // dropped.
    assign push      = (state_q == WAIT) && eng_cand_valid_i && !dup_hit && !fifo_full;
    assign pop       = out_valid_o && out_ready_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are live, and unreset storage maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{id: base_id_q, addr: eng_cand_addr_i};
        end
    end

    assign head        = fifo_mem[rd_ptr_q];
    assign out_valid_o = (count_q != '0);
    // Gate the head so the data outputs read zero while the FIFO is empty.
    assign out_addr_o  = out_valid_o ? head.addr : '0;
    assign out_id_o    = out_valid_o ? head.id   : '0;

endmodule

// File: tb/tb_prefetch_sched.sv
// -----------------------------------------------------------------------------
// tb_prefetch_sched
//
// Self-checking bench for prefetch_sched. Expected output candidates are pushed
// to a scoreboard queue when the engine stimulus is driven and compared by a
// monitor whenever the DUT completes an output handshake. Round-robin grants
// come from a table of {request mask, expected grant, candidate} records; the
// multi-cycle corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_prefetch_sched;

    localparam int AW = 32;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int TO = 64;

    logic               clock = 1'b0;
    logic               reset;
    logic [NR-1:0]      req_valid_i;
    logic [NR*AW-1:0]   req_addr_i;
    logic [NR-1:0]      req_ready_o;
    logic               eng_start_o;
    logic [AW-1:0]      eng_addr_o;
    logic               eng_cand_valid_i;
    logic [AW-1:0]      eng_cand_addr_i;
    logic               eng_done_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [AW-1:0]      out_addr_o;
    logic [IW-1:0]      out_id_o;
    logic               busy_o;
    logic               timeout_o;

    prefetch_sched #(
        .ADDR_WIDTH     (AW),
        .N_REQ          (NR),
        .MAX_CAND       (6),
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_addr_i       (req_addr_i),
        .req_ready_o      (req_ready_o),
        .eng_start_o      (eng_start_o),
        .eng_addr_o       (eng_addr_o),
        .eng_cand_valid_i (eng_cand_valid_i),
        .eng_cand_addr_i  (eng_cand_addr_i),
        .eng_done_i       (eng_done_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_addr_o       (out_addr_o),
        .out_id_o         (out_id_o),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
    } exp_t;

    typedef struct {
        logic [NR-1:0] rv;
        logic [NR-1:0] exp_grant;
        logic          has_cand;
        logic [AW-1:0] cand;
    } row_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   pop_count = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Output monitor: every handshake must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got addr 0x%0h id %0d, expected no output",
                         out_addr_o, out_id_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_addr", out_addr_o, e.addr);
                check("out_id", AW'(out_id_o), AW'(e.id));
            end
            pop_count++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input int k, input logic [AW-1:0] a);
        req_addr_i[k*AW +: AW] = a;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        req_valid_i      = '0;
        eng_cand_valid_i = 1'b0;
        eng_cand_addr_i  = '0;
        eng_done_i       = 1'b0;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits (bounded) for a grant; returns the sampled req_ready_o, or 0 if
    // none appeared, which the caller's comparison then reports.
    task automatic wait_grant(output logic [NR-1:0] got);
        got = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (req_ready_o != '0) begin
                got = req_ready_o;
                return;
            end
            tick();
        end
    endtask

    // Drives one engine cycle; the candidate is expected at the output if keep.
    task automatic cand(input logic [AW-1:0] a, input logic last,
                        input logic [IW-1:0] id, input logic keep);
        eng_cand_valid_i = 1'b1;
        eng_cand_addr_i  = a;
        eng_done_i       = last;
        if (keep) sb.push_back('{addr: a, id: id});
        tick();
        eng_cand_valid_i = 1'b0;
        eng_done_i       = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
        tick();
        check(name, AW'(sb.size()), '0);
    endtask

    function automatic logic [IW-1:0] onehot_id(input logic [NR-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = IW'(i);
        return r;
    endfunction

    initial begin
        row_t          rows [10];
        logic [NR-1:0] got;
        logic [IW-1:0] gid;
        logic [AW-1:0] single_cands [6];
        int            n;
        int            pop_base;
        logic          seen;

        rows[0] = '{4'b1111, 4'b0001, 1'b1, 32'h5000};
        rows[1] = '{4'b1111, 4'b0010, 1'b1, 32'h5001};
        rows[2] = '{4'b1111, 4'b0100, 1'b1, 32'h5002};
        rows[3] = '{4'b1111, 4'b1000, 1'b1, 32'h5003};
        rows[4] = '{4'b1111, 4'b0001, 1'b1, 32'h5004};
        rows[5] = '{4'b1010, 4'b0010, 1'b1, 32'h5005};
        rows[6] = '{4'b1001, 4'b1000, 1'b1, 32'h5006};
        rows[7] = '{4'b0110, 4'b0010, 1'b1, 32'h5007};
        rows[8] = '{4'b0011, 4'b0001, 1'b0, 32'h0};     // wrap, zero-candidate run
        rows[9] = '{4'b0001, 4'b0001, 1'b1, 32'h5009};

        single_cands[0] = 32'd12; single_cands[1] = 32'd14; single_cands[2] = 32'd10;
        single_cands[3] = 32'd16; single_cands[4] = 32'd4;  single_cands[5] = 32'd22;

        out_ready_i = 1'b1;
        req_addr_i  = '0;
        do_reset();

        // ---- reset state ----
        @(negedge clock);
        check("rst_busy", AW'(busy_o), '0);
        check("rst_out_valid", AW'(out_valid_o), '0);
        check("rst_req_ready", AW'(req_ready_o), '0);
        check("rst_start_timeout", AW'({eng_start_o, timeout_o}), '0);
        check("rst_eng_addr", eng_addr_o, '0);
        tick();

        // ---- stray candidate in IDLE is dropped (monitor flags any output) ----
        eng_cand_valid_i = 1'b1;
        eng_cand_addr_i  = 32'd99;
        eng_done_i       = 1'b1;
        tick();
        eng_cand_valid_i = 1'b0;
        eng_done_i       = 1'b0;
        @(negedge clock);
        check("stray_busy", AW'(busy_o), '0);
        tick();

        // ---- single run: requester 0, base 13 ----
        set_addr(0, 32'd13);
        req_valid_i = 4'b0001;
        @(negedge clock);
        check("single_ready", AW'(req_ready_o), AW'(4'b0001));
        tick();
        req_valid_i = '0;
        @(negedge clock);
        check("single_start", AW'(eng_start_o), AW'(1'b1));
        check("single_eng_addr", eng_addr_o, 32'd13);
        check("single_busy", AW'(busy_o), AW'(1'b1));
        tick();
        for (int i = 0; i < 6; i++) cand(single_cands[i], (i == 5), 2'd0, 1'b1);
        @(negedge clock);
        check("single_idle", AW'(busy_o), '0);
        check("single_start_low", AW'(eng_start_o), '0);
        drain("single_drain");

        // ---- round-robin table ----
        do_reset();
        for (int k = 0; k < NR; k++) set_addr(k, 32'h1000 + 32'(k) * 32'h100);
        for (int r = 0; r < 10; r++) begin
            req_valid_i = rows[r].rv;
            wait_grant(got);
            check($sformatf("rr_grant[%0d]", r), AW'(got), AW'(rows[r].exp_grant));
            gid = onehot_id(rows[r].exp_grant);
            tick();
            req_valid_i = '0;
            @(negedge clock);
            check($sformatf("rr_eng_addr[%0d]", r), eng_addr_o, 32'h1000 + 32'(gid) * 32'h100);
            tick();
            if (rows[r].has_cand) begin
                cand(rows[r].cand, 1'b1, gid, 1'b1);
            end else begin
                eng_done_i = 1'b1;
                tick();
                eng_done_i = 1'b0;
            end
        end
        drain("rr_drain");

        // ---- backpressure ----
        do_reset();
        out_ready_i = 1'b0;
        req_valid_i = 4'b0010;
        wait_grant(got);
        check("bp_grant1", AW'(got), AW'(4'b0010));
        tick();
        req_valid_i = '0;
        tick();
        for (int i = 0; i < 6; i++) cand(32'h7000 + 32'(i), (i == 5), 2'd1, 1'b1);
        req_valid_i = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (req_ready_o != '0) seen = 1'b1;
            tick();
        end
        check("bp_hold_off", AW'(seen), '0);
        @(negedge clock);
        check("bp_out_valid", AW'(out_valid_o), AW'(1'b1));
        tick();
        pop_base    = pop_count;
        out_ready_i = 1'b1;
        wait_grant(got);
        check("bp_grant2", AW'(got), AW'(4'b0100));
        check("bp_freed_enough", AW'((pop_count - pop_base) >= 4), AW'(1'b1));
        tick();
        req_valid_i = '0;
        out_ready_i = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) cand(32'h7100 + 32'(i), (i == 5), 2'd2, 1'b1);
        repeat (3) tick();
        out_ready_i = 1'b1;
        drain("bp_drain");

        // ---- watchdog ----
        do_reset();
        req_valid_i = 4'b0100;
        wait_grant(got);
        check("wd_grant", AW'(got), AW'(4'b0100));
        tick();
        req_valid_i = 4'b1000;
        tick();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            n++;
            @(negedge clock);
            if (timeout_o) break;
            tick();
        end
        check("wd_wait_cycles", AW'(n), AW'(TO));
        check("wd_no_grant_in_wait", AW'(req_ready_o), '0);
        tick();
        @(negedge clock);
        check("wd_pulse_once", AW'(timeout_o), '0);
        check("wd_next_grant", AW'(req_ready_o), AW'(4'b1000));
        tick();
        req_valid_i = '0;
        tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;

        // ---- reset mid-WAIT with buffered entries ----
        do_reset();
        out_ready_i = 1'b0;
        req_valid_i = 4'b0100;
        wait_grant(got);
        tick();
        req_valid_i = '0;
        tick();
        for (int i = 0; i < 3; i++) cand(32'h9000 + 32'(i), 1'b0, 2'd2, 1'b1);
        @(negedge clock);
        check("mid_out_valid", AW'(out_valid_o), AW'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", AW'(out_valid_o), '0);
        check("mid_rst_busy", AW'(busy_o), '0);
        sb.delete();
        tick();
        reset       = 1'b0;
        out_ready_i = 1'b1;
        tick();
        req_valid_i = 4'b1111;
        wait_grant(got);
        check("mid_rst_grant", AW'(got), AW'(4'b0001));
        tick();
        req_valid_i = '0;
        tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;

        // ---- duplicate filter (13 is expected only when no filter is built) ----
        do_reset();
        set_addr(0, 32'd13);
        set_addr(1, 32'd14);
        req_valid_i = 4'b0001;
        wait_grant(got);
        tick();
        req_valid_i = '0;
        tick();
        for (int i = 0; i < 6; i++) cand(single_cands[i], (i == 5), 2'd0, 1'b1);
        req_valid_i = 4'b0010;
        wait_grant(got);
        check("dedup_grant", AW'(got), AW'(4'b0010));
        tick();
        req_valid_i = '0;
        @(negedge clock);
        check("dedup_eng_addr", eng_addr_o, 32'd14);
        tick();
`ifdef PREFETCH_SCHED_DEDUP_EN
        cand(32'd13, 1'b0, 2'd1, 1'b0);
`else
        cand(32'd13, 1'b0, 2'd1, 1'b1);
`endif
        cand(32'd15, 1'b1, 2'd1, 1'b1);
        drain("dedup_drain");

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
